scan_decoder: RTL and testbench

- Parametrised, registered N-to-2^N one-hot decoder. Successor to the team's 3-to-8 gate-level decoder.
- Two modes:
  - Direct mode decodes an input select.
  - Scan mode walks the one-hot output through all positions. Each position is held for a programmable number of cycles, as a display digit / LED ring driver needs.
- Sits between control logic and multiplexed display or row/column drive.

---
 rtl/scan_decoder_pkg.sv | 25 ++
 rtl/scan_decoder_dwell_tick.sv | 31 +++
 rtl/scan_decoder.sv | 95 +++++++++
 tb/tb_scan_decoder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/scan_decoder_pkg.sv
// Shared types and helpers for the registered one-hot scan decoder.
package scan_decoder_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  localparam int MAX_OUT_W = 64;

  function automatic int cnt_w(input int dwell);
    return (dwell <= 1) ? 1 : $clog2(dwell);
  endfunction

  // Index 0 lands on the MSB when msb_first is set, matching the legacy decoder.
  function automatic logic [MAX_OUT_W-1:0] onehot_dec(input logic [5:0] idx,
                                                      input int out_w,
                                                      input logic msb_first);
    int pos;
    pos = int'(idx);
    if (msb_first) pos = out_w - 1 - pos;
    return 64'(1) << pos;
  endfunction

endpackage

// File: rtl/scan_decoder_dwell_tick.sv
// Dwell counter: tick marks the last cycle of a position while run is high.
module dwell_tick
  import scan_decoder_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int CW = cnt_w(DWELL);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] r_cnt;

  assign tick = run && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (run) begin
      r_cnt <= tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder with direct-select and dwell-timed scan modes.
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int SEL_W     = 3,
  parameter int DWELL     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  load,
  input  logic                  hold,
  input  logic [SEL_W-1:0]      sel,
  output logic [2**SEL_W-1:0]   f,
  output logic [SEL_W-1:0]      idx,
  output logic                  valid,
  output logic                  wrap
);

  localparam int OUT_W = 2**SEL_W;

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  mode_e            w_mode;
  logic             w_dir;
  logic             w_load;
  logic             w_run;
  logic             w_tick;
  logic [SEL_W-1:0] w_idx_next;
  logic             w_wrap_next;
  logic [OUT_W-1:0] w_dec;

  logic [SEL_W-1:0] r_idx;
  logic [OUT_W-1:0] r_f;
  logic             r_valid;
  logic             r_wrap;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= '0;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_mode = mode_e'(mode);
  assign w_dir  = en && (w_mode == MODE_DIRECT);
  assign w_load = en && (w_mode == MODE_SCAN) && load;
  assign w_run  = en && (w_mode == MODE_SCAN) && !load && !hold;

  dwell_tick #(
    .DWELL(DWELL)
  ) u_dwell_tick (
    .clk  (clk),
    .rst_n(w_rst_n),
    .clr  (w_dir || w_load),
    .run  (w_run),
    .tick (w_tick)
  );

  // Priority: direct/load take sel, then a dwell tick advances, otherwise hold.
  always_comb begin
    w_idx_next  = r_idx;
    w_wrap_next = 1'b0;
    if (w_dir || w_load) begin
      w_idx_next = sel;
    end else if (w_tick) begin
      w_idx_next  = r_idx + 1'b1;
      w_wrap_next = &r_idx;
    end
  end

  assign w_dec = OUT_W'(onehot_dec(6'(w_idx_next), OUT_W, MSB_FIRST != 0));

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_idx   <= '0;
      r_f     <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_idx   <= w_idx_next;
      r_f     <= en ? w_dec : '0;
      r_valid <= en;
      r_wrap  <= w_wrap_next;
    end
  end

  assign f     = r_f;
  assign idx   = r_idx;
  assign valid = r_valid;
  assign wrap  = r_wrap;

endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: DWELL=4/MSB-first and DWELL=1/LSB-first instances share stimulus.
module tb_scan_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, mode, load, hold;
  logic [2:0] sel;

  logic [7:0] fa, fb;
  logic [2:0] idxa, idxb;
  logic       va, vb, wa, wb;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] f;
    logic [2:0] idx;
    logic       valid;
    logic       wrap;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int ma_idx, ma_cnt, mb_idx, mb_cnt;

  always #5 clk = ~clk;

  scan_decoder #(.SEL_W(3), .DWELL(4), .MSB_FIRST(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .hold(hold),
    .sel(sel), .f(fa), .idx(idxa), .valid(va), .wrap(wa)
  );

  scan_decoder #(.SEL_W(3), .DWELL(1), .MSB_FIRST(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .hold(hold),
    .sel(sel), .f(fb), .idx(idxb), .valid(vb), .wrap(wb)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int dwell, input bit msbf,
                            inout int m_idx, inout int m_cnt, output exp_t e);
    e = '0;
    if (en) begin
      if (!mode || load) begin
        m_idx = int'(sel);
        m_cnt = 0;
      end else if (!hold) begin
        if (m_cnt == dwell - 1) begin
          m_cnt  = 0;
          m_idx  = (m_idx + 1) % 8;
          e.wrap = (m_idx == 0);
        end else begin
          m_cnt++;
        end
      end
      e.valid = 1'b1;
      e.f     = msbf ? (8'h80 >> m_idx) : (8'h01 << m_idx);
    end
    e.idx = 3'(m_idx);
  endtask

  task automatic step(input string tag);
    exp_t ea, eb, pa, pb;
    model_step(4, 1'b1, ma_idx, ma_cnt, ea);
    qa.push_back(ea);
    model_step(1, 1'b0, mb_idx, mb_cnt, eb);
    qb.push_back(eb);
    @(posedge clk);
    #1;
    pa = qa.pop_front();
    pb = qb.pop_front();
    check_val({tag, "_a"}, {19'd0, fa, idxa, va, wa}, {19'd0, pa});
    check_val({tag, "_b"}, {19'd0, fb, idxb, vb, wb}, {19'd0, pb});
  endtask

  task automatic model_reset();
    ma_idx = 0; ma_cnt = 0; mb_idx = 0; mb_cnt = 0;
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_a"}, {19'd0, fa, idxa, va, wa}, 32'd0);
    check_val({tag, "_b"}, {19'd0, fb, idxb, vb, wb}, 32'd0);
  endtask

  initial begin
    logic [7:0] msb_tbl [8];
    msb_tbl = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; load = 1'b0; hold = 1'b0; sel = '0;
    model_reset();
    #12;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step("post_reset");

    // Direct decode of every select value
    en = 1'b1; mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      step("direct");
      check_val("direct_f", {24'd0, fa}, {24'd0, msb_tbl[i]});
      check_val("direct_idx", {29'd0, idxa}, i);
    end

    // Scan from 6 through the wrap
    mode = 1'b1; load = 1'b1; sel = 3'd6;
    step("scan_load");
    check_val("scan_load_f", {24'd0, fa}, 32'h02);
    load = 1'b0;
    for (int i = 0; i < 7; i++) step("scan_walk");
    check_val("scan_idx7", {29'd0, idxa}, 32'd7);
    check_val("scan_f7", {24'd0, fa}, 32'h01);
    step("scan_wrap");
    check_val("scan_wrap_idx", {29'd0, idxa}, 32'd0);
    check_val("scan_wrap_pulse", {31'd0, wa}, 32'd1);
    check_val("scan_wrap_f", {24'd0, fa}, 32'h80);
    step("scan_after_wrap");
    check_val("scan_wrap_clear", {31'd0, wa}, 32'd0);

    // Hold mid-dwell at idx=2, cnt=1
    load = 1'b1; sel = 3'd2;
    step("hold_load");
    load = 1'b0;
    step("hold_cnt1");
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("hold_on");
      check_val("hold_idx", {29'd0, idxa}, 32'd2);
    end
    hold = 1'b0;
    step("hold_rel1");
    step("hold_rel2");
    check_val("hold_rem_idx", {29'd0, idxa}, 32'd2);
    step("hold_rel3");
    check_val("hold_adv_idx", {29'd0, idxa}, 32'd3);
    hold = 1'b1; load = 1'b1; sel = 3'd5;
    step("load_beats_hold");
    check_val("load_wins_idx", {29'd0, idxa}, 32'd5);
    hold = 1'b0; load = 1'b0;

    // Enable gap at idx=5 with cnt=1 preserved
    step("gap_pre");
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step("gap");
      check_val("gap_f", {24'd0, fa}, 32'd0);
      check_val("gap_valid", {31'd0, va}, 32'd0);
    end
    en = 1'b1;
    step("resume1");
    step("resume2");
    check_val("resume_idx5", {29'd0, idxa}, 32'd5);
    step("resume3");
    check_val("resume_idx6", {29'd0, idxa}, 32'd6);

    // DWELL=1, LSB-first walk
    load = 1'b1; sel = 3'd0;
    for (int k = 0; k < 10; k++) begin
      step("dwell1");
      load = 1'b0;
      check_val("dwell1_f", {24'd0, fb}, 32'd1 << (k % 8));
      check_val("dwell1_wrap", {31'd0, wb}, (k == 8) ? 32'd1 : 32'd0);
    end

    // Asynchronous reset mid-scan at idx=4
    load = 1'b1; sel = 3'd4;
    step("pre_reset");
    check_val("pre_reset_idx", {29'd0, idxa}, 32'd4);
    load = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    model_reset();
    #1 rst_n = 1'b1;
    en = 1'b0;
    for (int i = 0; i < 3; i++) step("rst_release");
    en = 1'b1; mode = 1'b0; sel = 3'd3;
    step("post_rst_direct");
    check_val("post_rst_f_a", {24'd0, fa}, 32'h10);
    check_val("post_rst_f_b", {24'd0, fb}, 32'h08);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
